logic_seq_32: RTL and testbench



---
 rtl/logic_seq_32_pkg.sv | 47 ++++
 rtl/logic_seq_32_nor.sv | 10 +
 rtl/logic_seq_32.sv | 203 ++++++++++++++++++++
 tb/tb_logic_seq_32.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/logic_seq_32_pkg.sv
// Shared encodings for the multi-cycle NOR-based logic unit:
// operation codes, FSM states, pass counts and pass destinations.
package logic_seq_32_pkg;

  localparam logic [2:0] OP_NOR  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_XNOR = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_NOTA = 3'd5;

  localparam logic [2:0] PASSES_NOR   = 3'd1;
  localparam logic [2:0] PASSES_OR    = 3'd2;
  localparam logic [2:0] PASSES_AND   = 3'd3;
  localparam logic [2:0] PASSES_XNOR  = 3'd4;
  localparam logic [2:0] PASSES_XOR   = 3'd5;
  localparam logic [2:0] PASSES_NOTA  = 3'd1;
  localparam logic [2:0] PASSES_UNDEF = 3'd1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    FIN  = 2'd2
  } state_e;

  // Where the result of the current NOR pass is written
  typedef enum logic [1:0] {
    DST_T1 = 2'd0,
    DST_T2 = 2'd1,
    DST_YT = 2'd2,
    DST_Y  = 2'd3
  } dst_e;

  // Number of NOR passes an operation spends in EXEC
  function automatic logic [2:0] pass_count(input logic [2:0] op);
    case (op)
      OP_NOR:  pass_count = PASSES_NOR;
      OP_OR:   pass_count = PASSES_OR;
      OP_AND:  pass_count = PASSES_AND;
      OP_XNOR: pass_count = PASSES_XNOR;
      OP_XOR:  pass_count = PASSES_XOR;
      OP_NOTA: pass_count = PASSES_NOTA;
      default: pass_count = PASSES_UNDEF;
    endcase
  endfunction

endpackage

// File: rtl/logic_seq_32_nor.sv
// 32-bit NOR array: the single shared logic datapath of logic_seq_32.
module nor_32 (
  input  logic [31:0] x,
  input  logic [31:0] z,
  output logic [31:0] n
);

  assign n = ~(x | z);

endmodule

// File: rtl/logic_seq_32.sv
// Multi-cycle 32-bit logic unit. Every result is built from NOR passes
// through one shared nor_32 array, sequenced by a small FSM. START is
// accepted in IDLE or FIN; DONE pulses once per operation with Y valid.
module logic_seq_32
  import logic_seq_32_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
  input  logic [2:0]  OP,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] Y,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERR
);

  state_e      state_r;
  state_e      state_nx_s;
  logic [2:0]  op_r;
  logic [2:0]  step_r;
  logic [31:0] ra_r;
  logic [31:0] rb_r;
  logic [31:0] t1_r;
  logic [31:0] t2_r;
  logic [31:0] yt_r;
  logic [31:0] y_r;
  logic        busy_r;
  logic        done_r;
  logic        err_r;

  logic [31:0] x_s;
  logic [31:0] z_s;
  logic [31:0] n_s;
  dst_e        dst_s;
  logic        undef_s;
  logic        last_s;
  logic        accept_s;
  logic        exec_s;

  nor_32 u_nor (
    .x (x_s),
    .z (z_s),
    .n (n_s)
  );

  assign exec_s = (state_r == EXEC);
  assign last_s = (step_r == (pass_count(op_r) - 3'd1));

  // Operand selection and destination for the current NOR pass
  always_comb begin
    x_s     = ra_r;
    z_s     = rb_r;
    dst_s   = DST_Y;
    undef_s = 1'b0;
    case (op_r)
      OP_NOR: begin
        x_s   = ra_r;
        z_s   = rb_r;
        dst_s = DST_Y;
      end
      OP_OR: begin
        case (step_r)
          3'd0:    begin x_s = ra_r; z_s = rb_r; dst_s = DST_T1; end
          default: begin x_s = t1_r; z_s = t1_r; dst_s = DST_Y;  end
        endcase
      end
      OP_AND: begin
        case (step_r)
          3'd0:    begin x_s = ra_r; z_s = ra_r; dst_s = DST_T1; end
          3'd1:    begin x_s = rb_r; z_s = rb_r; dst_s = DST_T2; end
          default: begin x_s = t1_r; z_s = t2_r; dst_s = DST_Y;  end
        endcase
      end
      OP_XNOR, OP_XOR: begin
        // XOR runs the XNOR chain into yt_r, then inverts it onto Y
        case (step_r)
          3'd0: begin x_s = ra_r; z_s = rb_r; dst_s = DST_T1; end
          3'd1: begin x_s = ra_r; z_s = t1_r; dst_s = DST_T2; end
          3'd2: begin x_s = rb_r; z_s = t1_r; dst_s = DST_T1; end
          3'd3: begin
            x_s = t2_r;
            z_s = t1_r;
            if (op_r == OP_XOR) begin
              dst_s = DST_YT;
            end else begin
              dst_s = DST_Y;
            end
          end
          default: begin x_s = yt_r; z_s = yt_r; dst_s = DST_Y; end
        endcase
      end
      OP_NOTA: begin
        x_s   = ra_r;
        z_s   = ra_r;
        dst_s = DST_Y;
      end
      default: begin
        undef_s = 1'b1;
        dst_s   = DST_Y;
      end
    endcase
  end

  // Next-state decode and START acceptance
  always_comb begin
    state_nx_s = state_r;
    accept_s   = 1'b0;
    case (state_r)
      IDLE, FIN: begin
        if (START) begin
          accept_s   = 1'b1;
          state_nx_s = EXEC;
        end else begin
          state_nx_s = IDLE;
        end
      end
      EXEC: begin
        if (last_s) begin
          state_nx_s = FIN;
        end else begin
          state_nx_s = EXEC;
        end
      end
      default: begin
        state_nx_s = IDLE;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Latch operands and opcode on an accepted START
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ra_r <= 32'd0;
      rb_r <= 32'd0;
      op_r <= 3'd0;
    end else if (accept_s) begin
      ra_r <= A;
      rb_r <= B;
      op_r <= OP;
    end
  end

  // Pass step counter: cleared on accept, advanced each non-final pass
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      step_r <= 3'd0;
    end else if (accept_s) begin
      step_r <= 3'd0;
    end else if (exec_s && !last_s) begin
      step_r <= step_r + 3'd1;
    end
  end

  // Temp registers capture intermediate NOR results
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      t1_r <= 32'd0;
      t2_r <= 32'd0;
      yt_r <= 32'd0;
    end else if (exec_s) begin
      case (dst_s)
        DST_T1:  t1_r <= n_s;
        DST_T2:  t2_r <= n_s;
        DST_YT:  yt_r <= n_s;
        default: t1_r <= t1_r;
      endcase
    end
  end

  // Result and status outputs, updated only on the final pass edge
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      y_r    <= 32'd0;
      done_r <= 1'b0;
      err_r  <= 1'b0;
      busy_r <= 1'b0;
    end else begin
      busy_r <= (state_nx_s == EXEC);
      done_r <= exec_s && last_s;
      err_r  <= exec_s && last_s && undef_s;
      if (exec_s && last_s) begin
        y_r <= undef_s ? 32'd0 : n_s;
      end
    end
  end

  assign Y    = y_r;
  assign BUSY = busy_r;
  assign DONE = done_r;
  assign ERR  = err_r;

endmodule

// File: tb/tb_logic_seq_32.sv
// Scoreboard bench for logic_seq_32: a behavioural model pushes the
// expected result and completion cycle on each accepted START; a monitor
// on the falling edge pops and compares whenever DONE is seen.
module tb_logic_seq_32;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        START = 1'b0;
  logic [2:0]  OP = 3'd0;
  logic [31:0] A = 32'd0;
  logic [31:0] B = 32'd0;
  logic [31:0] Y;
  logic        BUSY;
  logic        DONE;
  logic        ERR;

  typedef struct {
    logic [31:0] y;
    logic        err;
    int          due;
  } exp_t;

  exp_t        sbq[$];
  exp_t        e_mon;
  int          cnt_m = 0;
  int          cyc = 0;
  logic [31:0] y_hold = 32'd0;
  int          checks = 0;
  int          errors = 0;

  logic_seq_32 dut (
    .CLK   (CLK),
    .RST   (RST),
    .START (START),
    .OP    (OP),
    .A     (A),
    .B     (B),
    .Y     (Y),
    .BUSY  (BUSY),
    .DONE  (DONE),
    .ERR   (ERR)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] ref_y(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      3'd0: return ~(a | b);
      3'd1: return a | b;
      3'd2: return a & b;
      3'd3: return ~(a ^ b);
      3'd4: return a ^ b;
      3'd5: return ~a;
      default: return 32'd0;
    endcase
  endfunction

  function automatic int passes(input logic [2:0] op);
    case (op)
      3'd1: return 2;
      3'd2: return 3;
      3'd3: return 4;
      3'd4: return 5;
      default: return 1;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Reference model: tracks occupancy and queues expected results on accept
  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sbq.delete();
      cnt_m <= 0;
    end else begin
      cyc <= cyc + 1;
      if (cnt_m > 0) begin
        cnt_m <= cnt_m - 1;
      end else if (START) begin
        sbq.push_back('{ref_y(OP, A, B), (OP > 3'd5), cyc + 1 + passes(OP)});
        cnt_m <= passes(OP);
      end
    end
  end

  // Monitor: compare status each cycle and pop the scoreboard on DONE
  always @(negedge CLK) begin
    if (!RST) begin
      y_hold = 32'd0;
    end else begin
      check("busy", {31'd0, BUSY}, {31'd0, (cnt_m > 0)});
      if (DONE) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_done: got DONE=1 expected no pending result at cycle %0d", cyc);
        end else begin
          e_mon = sbq.pop_front();
          check("result_y", Y, e_mon.y);
          check("result_err", {31'd0, ERR}, {31'd0, e_mon.err});
          check("done_cycle", cyc, e_mon.due);
          y_hold = e_mon.y;
        end
      end else begin
        check("y_hold", Y, y_hold);
        check("err_idle", {31'd0, ERR}, 32'd0);
      end
    end
  end

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    START = 1'b1;
    OP    = op;
    A     = a;
    B     = b;
    @(negedge CLK);
    START = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 20 && cnt_m != 0; i++) @(negedge CLK);
    if (cnt_m != 0) begin
      checks++;
      errors++;
      $display("FAIL wait_idle_timeout: got busy after 20 cycles expected completion");
    end
  endtask

  initial begin
    RST = 1'b0;
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    check("reset_y", Y, 32'd0);
    check("reset_busy", {31'd0, BUSY}, 32'd0);
    check("reset_done", {31'd0, DONE}, 32'd0);

    // Every opcode with the reference operands, from IDLE
    for (int op = 0; op < 8; op++) begin
      issue(op[2:0], 32'hF0F0F0F0, 32'hFF00FF00);
      wait_idle();
      @(negedge CLK);
    end

    // START while busy is ignored
    issue(3'd4, 32'hF0F0F0F0, 32'hFF00FF00);
    @(negedge CLK);
    issue(3'd0, 32'h12345678, 32'h9ABCDEF0);
    wait_idle();
    @(negedge CLK);

    // Back-to-back: START held in the FIN cycle of an OR
    issue(3'd1, 32'hF0F0F0F0, 32'hFF00FF00);
    wait_idle();
    issue(3'd2, 32'hF0F0F0F0, 32'hFF00FF00);
    wait_idle();
    @(negedge CLK);

    // Operand changes during EXEC have no effect
    issue(3'd1, 32'h0000FFFF, 32'h00FF0000);
    for (int i = 0; i < 3; i++) begin
      A = $urandom;
      B = $urandom;
      @(negedge CLK);
    end
    wait_idle();
    @(negedge CLK);

    // Randomized operations, gaps and ignored STARTs
    for (int i = 0; i < 40; i++) begin
      issue(3'($urandom_range(0, 7)), $urandom, $urandom);
      if ($urandom_range(0, 2) == 0) issue(3'($urandom_range(0, 7)), $urandom, $urandom);
      wait_idle();
      repeat ($urandom_range(0, 1)) @(negedge CLK);
    end
    wait_idle();
    @(negedge CLK);

    // Reset in the middle of an XOR
    issue(3'd4, 32'hF0F0F0F0, 32'hFF00FF00);
    @(negedge CLK);
    #2 RST = 1'b0;
    #1;
    check("midreset_y", Y, 32'd0);
    check("midreset_busy", {31'd0, BUSY}, 32'd0);
    check("midreset_done", {31'd0, DONE}, 32'd0);
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    repeat (8) @(negedge CLK);

    for (int i = 0; i < 30 && sbq.size() != 0; i++) @(negedge CLK);
    if (sbq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending results expected 0", sbq.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
